// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain controller.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAP_SETUP,
    CAP_PULSE,
    CAP_HOLD,
    SHIFT,
    UPD_GAP,
    UPD_PULSE,
    FIN
  } state_t;

  typedef enum logic [1:0] {
    PH_P1 = 2'd0,
    PH_G1 = 2'd1,
    PH_P2 = 2'd2,
    PH_G2 = 2'd3
  } phase_t;

  localparam int unsigned OP_CAPTURE = 0;
  localparam int unsigned OP_UPDATE  = 1;

endpackage

// File: rtl/scan_phase_gen.sv
// Four-phase shift sequencer and bit counter; phase reflects the current SHIFT cycle.
module scan_phase_gen
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   enable,
  input  logic   clear,
  output phase_t phase,
  output logic   last_bit,
  output logic   sample
);

  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase   <= PH_P1;
      bit_cnt <= '0;
    end else if (enable) begin
      phase <= phase_t'(phase + 2'd1);
      if (phase == PH_G2) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign last_bit = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  // Strobe is high during P1, so the capturing edge is the one that ends P1.
  assign sample   = enable && (phase == PH_P1);

endmodule

// File: rtl/scan_chain_ctrl.sv
// LSSD scan chain controller: optional capture, CHAIN_LEN-bit two-phase shift, optional update.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic [1:0]           OP,
  input  logic [CHAIN_LEN-1:0] WDATA,
  input  logic                 SCAN_OUT,
  output logic                 SCAN_IN,
  output logic                 SCAN_CLK1,
  output logic                 SCAN_CLK2,
  output logic                 SCAN_CAPTURE,
  output logic                 SCAN_UPDATE,
  output logic [CHAIN_LEN-1:0] RDATA,
  output logic                 BUSY,
  output logic                 DONE
);

  state_t               state;
  phase_t               phase;
  logic                 last_bit;
  logic                 sample;
  logic                 in_shift;
  logic                 do_update;
  logic [CHAIN_LEN-1:0] wreg;

  assign in_shift = (state == SHIFT);

  scan_phase_gen #(
    .CHAIN_LEN(CHAIN_LEN),
    .CNT_W    (CNT_W)
  ) u_phase (
    .clk     (CLK),
    .reset   (RESET),
    .enable  (in_shift),
    .clear   (!in_shift),
    .phase   (phase),
    .last_bit(last_bit),
    .sample  (sample)
  );

  // Outputs are loaded with the values for the state being entered, so every
  // chain control comes straight from a flop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      wreg         <= '0;
      do_update    <= 1'b0;
      SCAN_IN      <= 1'b0;
      SCAN_CLK1    <= 1'b0;
      SCAN_CLK2    <= 1'b0;
      SCAN_CAPTURE <= 1'b0;
      SCAN_UPDATE  <= 1'b0;
      RDATA        <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      SCAN_CLK1    <= 1'b0;
      SCAN_CLK2    <= 1'b0;
      SCAN_CAPTURE <= 1'b0;
      SCAN_UPDATE  <= 1'b0;
      DONE         <= 1'b0;
      if (sample) RDATA <= {RDATA[CHAIN_LEN-2:0], SCAN_OUT};

      case (state)
        IDLE: begin
          if (START) begin
            wreg      <= WDATA;
            do_update <= OP[OP_UPDATE];
            BUSY      <= 1'b1;
            if (OP[OP_CAPTURE]) begin
              state        <= CAP_SETUP;
              SCAN_CAPTURE <= 1'b1;
            end else begin
              state     <= SHIFT;
              SCAN_CLK1 <= 1'b1;
              SCAN_IN   <= WDATA[CHAIN_LEN-1];
            end
          end
        end
        CAP_SETUP: begin
          state        <= CAP_PULSE;
          SCAN_CAPTURE <= 1'b1;
          SCAN_CLK2    <= 1'b1;
        end
        CAP_PULSE: begin
          state        <= CAP_HOLD;
          SCAN_CAPTURE <= 1'b1;
        end
        CAP_HOLD: begin
          state     <= SHIFT;
          SCAN_CLK1 <= 1'b1;
          SCAN_IN   <= wreg[CHAIN_LEN-1];
        end
        SHIFT: begin
          case (phase)
            PH_G1: SCAN_CLK2 <= 1'b1;
            PH_G2: begin
              if (last_bit) begin
                SCAN_IN <= 1'b0;
                if (do_update) begin
                  state <= UPD_GAP;
                end else begin
                  state <= FIN;
                  DONE  <= 1'b1;
                end
              end else begin
                SCAN_CLK1 <= 1'b1;
                SCAN_IN   <= wreg[CHAIN_LEN-2];
                wreg      <= {wreg[CHAIN_LEN-2:0], 1'b0};
              end
            end
            default: ;
          endcase
        end
        UPD_GAP: begin
          state       <= UPD_PULSE;
          SCAN_UPDATE <= 1'b1;
        end
        UPD_PULSE: begin
          state <= FIN;
          DONE  <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: behavioural LSSD chain, per-cycle trace model, directed and random runs.
module tb_scan_chain_ctrl;
  localparam int N = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic [1:0]   OP = 2'b00;
  logic [N-1:0] WDATA = '0;
  logic         SCAN_OUT;
  logic         SCAN_IN, SCAN_CLK1, SCAN_CLK2, SCAN_CAPTURE, SCAN_UPDATE, BUSY, DONE;
  logic [N-1:0] RDATA;

  always #5 CLK = ~CLK;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .WDATA(WDATA), .SCAN_OUT(SCAN_OUT),
    .SCAN_IN(SCAN_IN), .SCAN_CLK1(SCAN_CLK1), .SCAN_CLK2(SCAN_CLK2), .SCAN_CAPTURE(SCAN_CAPTURE),
    .SCAN_UPDATE(SCAN_UPDATE), .RDATA(RDATA), .BUSY(BUSY), .DONE(DONE)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Behavioural chain: cell i master/slave, cell N-1 slave drives SCAN_OUT.
  logic [N-1:0] ms = '0, sl = '0, upd_q = '0, cap_in = '0, pre_val = '0;
  logic         upd_prev = 1'b0;
  int           pre_seq = 0, pre_done = 0;
  assign SCAN_OUT = sl[N-1];

  // Expected per-cycle trace of one operation.
  typedef struct packed {
    logic clk1, clk2, cap, upd, busy, done, si_chk, si;
  } exp_t;
  exp_t         q[$];
  exp_t         cur = '0;
  logic [N-1:0] exp_rdata = '0, pend_rdata = '0, cur_wd = '0;
  logic [1:0]   cur_op = 2'b00;
  bit           armed = 1'b0;

  task automatic build(input logic [1:0] op, input logic [N-1:0] wd);
    exp_t e;
    if (op[0]) begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.busy = 1'b1; e.cap = 1'b1; e.clk2 = (i == 1);
        q.push_back(e);
      end
    end
    for (int b = 0; b < N; b++) begin
      for (int p = 0; p < 4; p++) begin
        e = '0; e.busy = 1'b1; e.clk1 = (p == 0); e.clk2 = (p == 2);
        e.si_chk = 1'b1; e.si = wd[N-1-b];
        q.push_back(e);
      end
    end
    if (op[1]) begin
      e = '0; e.busy = 1'b1; q.push_back(e);
      e.upd = 1'b1; q.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1; q.push_back(e);
  endtask

  always @(posedge CLK) begin
    if (RESET) begin
      q.delete(); cur = '0; exp_rdata = '0; armed = 1'b1;
    end else if (!cur.busy && START) begin
      cur_op = OP; cur_wd = WDATA;
      pend_rdata = OP[0] ? cap_in : sl;
      build(OP, WDATA);
      cur = q.pop_front();
    end else if (q.size() != 0) begin
      cur = q.pop_front();
    end else begin
      cur = '0;
    end
    if (cur.done) exp_rdata = pend_rdata;
  end

  // Chain evaluation and per-cycle comparison, mid-cycle.
  always @(negedge CLK) begin
    if (pre_seq != pre_done) begin
      sl = pre_val; ms = pre_val; pre_done = pre_seq;
    end
    if (SCAN_CLK1) ms = {sl[N-2:0], SCAN_IN};
    if (SCAN_CLK2) sl = SCAN_CAPTURE ? cap_in : ms;
    if (SCAN_UPDATE && !upd_prev) upd_q = sl;
    upd_prev = SCAN_UPDATE;
    if (armed) begin
      chk("ctrl", 32'({SCAN_CLK1, SCAN_CLK2, SCAN_CAPTURE, SCAN_UPDATE, BUSY, DONE}),
                  32'({cur.clk1, cur.clk2, cur.cap, cur.upd, cur.busy, cur.done}));
      chk("clk_overlap", 32'(SCAN_CLK1 & SCAN_CLK2), 32'd0);
      if (cur.si_chk) chk("scan_in", 32'(SCAN_IN), 32'(cur.si));
      if (cur.done || !cur.busy) chk("rdata", 32'(RDATA), 32'(exp_rdata));
      if (cur.done) begin
        chk("chain_after", 32'(sl), 32'(cur_wd));
        if (cur_op[1]) chk("upd_out", 32'(upd_q), 32'(cur_wd));
      end
    end
  end

  task automatic preload(input logic [N-1:0] v);
    pre_val = v; pre_seq++;
    @(negedge CLK); #1;
  endtask

  int           r_busy, r_c1, r_c2, r_upd, r_cap, r_gap;
  logic [N-1:0] r_rd;

  task automatic run(input logic [1:0] op, input logic [N-1:0] wd, input logic [N-1:0] cap,
                     input int ign_at, input bit ign_fin);
    int last_c2;
    bit seen;
    r_busy = 0; r_c1 = 0; r_c2 = 0; r_upd = 0; r_cap = 0; r_gap = -1; r_rd = '0;
    last_c2 = 0; seen = 1'b0;
    cap_in = cap; OP = op; WDATA = wd; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; WDATA = ~wd; OP = ~op;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge CLK);
      if (START) START = 1'b0;
      if (k == ign_at) START = 1'b1;
      if (BUSY) r_busy++;
      if (SCAN_CLK1) r_c1++;
      if (SCAN_CLK2) begin r_c2++; last_c2 = k; end
      if (SCAN_CAPTURE) r_cap++;
      if (SCAN_UPDATE) begin r_upd++; r_gap = k - last_c2; end
      if (DONE) begin
        seen = 1'b1; r_rd = RDATA;
        if (ign_fin) START = 1'b1;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL timeout: no DONE within 200 cycles, required DONE");
    end
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  initial begin
    int nd;
    logic [1:0]   op;
    logic [N-1:0] wd;

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", 32'({SCAN_IN, SCAN_CLK1, SCAN_CLK2, SCAN_CAPTURE, SCAN_UPDATE, BUSY, DONE, RDATA}), 32'd0);
    RESET = 1'b0;

    preload(8'h3C);
    run(2'b00, 8'hA5, 8'h00, -1, 1'b0);
    chk("op00_rdata", 32'(r_rd), 32'h3C);
    chk("op00_chain", 32'(sl), 32'hA5);
    chk("op00_busy", 32'(r_busy), 32'd33);
    chk("op00_upd_cap", 32'(r_upd + r_cap), 32'd0);
    chk("op00_clk1", 32'(r_c1), 32'd8);

    preload(8'h00);
    run(2'b11, 8'hFF, 8'h5A, -1, 1'b0);
    chk("op11_rdata", 32'(r_rd), 32'h5A);
    chk("op11_upd_out", 32'(upd_q), 32'hFF);
    chk("op11_busy", 32'(r_busy), 32'd38);
    chk("op11_upd_cnt", 32'(r_upd), 32'd1);
    // last CLK2 is P2; G2 follows, then the update lands two cycles later
    chk("op11_upd_gap", 32'(r_gap), 32'd3);
    chk("op11_clk2", 32'(r_c2), 32'd9);

    run(2'b00, 8'h96, 8'h00, 10, 1'b1);
    nd = 0;
    repeat (10) begin
      @(negedge CLK);
      if (BUSY || DONE) nd++;
    end
    chk("ignored_start", 32'(nd), 32'd0);
    chk("ignored_busy", 32'(r_busy), 32'd33);

    preload(8'h3C);
    cap_in = '0; OP = 2'b00; WDATA = 8'hC3; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (14) @(negedge CLK);
    @(negedge CLK);
    chk("p2_bit3_clk2", 32'(SCAN_CLK2), 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("abort_outs", 32'({SCAN_IN, SCAN_CLK1, SCAN_CLK2, SCAN_CAPTURE, SCAN_UPDATE, BUSY, DONE, RDATA}), 32'd0);
    nd = 0;
    repeat (4) begin
      @(negedge CLK);
      if (BUSY || DONE) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    preload(8'h3C);
    run(2'b00, 8'h0F, 8'h00, -1, 1'b0);
    chk("post_abort_busy", 32'(r_busy), 32'd33);
    chk("post_abort_rdata", 32'(r_rd), 32'h3C);

    for (int i = 0; i < 25; i++) begin
      op = 2'($urandom_range(0, 3));
      wd = N'($urandom);
      if ($urandom_range(0, 1) == 1) preload(N'($urandom));
      run(op, wd, N'($urandom), -1, 1'b0);
      chk("rnd_busy", 32'(r_busy), 32'(3 * int'(op[0]) + 4 * N + 2 * int'(op[1]) + 1));
      chk("rnd_clk1", 32'(r_c1), 32'(N));
      chk("rnd_clk2", 32'(r_c2), 32'(N + int'(op[0])));
      chk("rnd_upd", 32'(r_upd), 32'(op[1]));
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
